// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_arbiter
//  Description : 8-way round-robin arbiter. It grants without preemption and
//                limits how many consecutive cycles one requester may hold
//                the grant. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module round_robin_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy
);

    // Last hold_cnt value before a forced release (MAX_HOLD is 2..256).
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_owner;
    logic [7:0] r_hold;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [2:0] w_ptr_nxt;
    logic [2:0] w_owner_nxt;
    logic [7:0] w_hold_nxt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] w_gnt_id_nxt;
    logic       w_busy_nxt;

    logic       w_found;
    logic [2:0] w_winner;
    logic [2:0] w_idx;

    // Circular priority search: the first set request at or after r_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        w_idx    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_idx = r_ptr + 3'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state and next-output logic. Defaults hold the current state.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_owner_nxt  = r_owner;
        w_hold_nxt   = r_hold;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_busy_nxt   = r_busy;
        case (r_state)
            IDLE: begin
                w_gnt_nxt    = 8'd0;
                w_gnt_id_nxt = 3'd0;
                w_busy_nxt   = 1'b0;
                if (w_found) begin
                    w_state_nxt  = GRANT;
                    w_owner_nxt  = w_winner;
                    w_gnt_nxt    = 8'd1 << w_winner;
                    w_gnt_id_nxt = w_winner;
                    w_busy_nxt   = 1'b1;
                    w_hold_nxt   = 8'd0;
                end
            end
            GRANT: begin
                // Only the owner's request matters here; other bits are ignored.
                if (req[r_owner] && (r_hold != c_HOLD_LAST)) begin
                    w_hold_nxt = r_hold + 8'd1;
                end else begin
                    // A dropped request and an expired hold collapse into one release.
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = 8'd0;
                    w_gnt_id_nxt = 3'd0;
                    w_busy_nxt   = 1'b0;
                    w_ptr_nxt    = r_owner + 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides everything, including an active grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= 3'd0;
            r_owner  <= 3'd0;
            r_hold   <= 8'd0;
            r_gnt    <= 8'd0;
            r_gnt_id <= 3'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_hold   <= w_hold_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule
`default_nettype wire
